reaction_timer_core: RTL and testbench
======================================

# reaction_timer_core

Parametrised, fully synchronous reaction-time game engine. It generates a pseudo-random wait, times the player's response in BCD ticks, detects false starts and overflow, and keeps a best (lowest) score. It sits between the debounced button pulses and the seven-segment/LED output muxing of the game top level, and replaces the ad-hoc multi-clock state machine with a single-clock core.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 100: timing resolution (ticks per second); `DIV = CLK_HZ/TICK_HZ`, must be an integer ≥ 2.
- `DIGITS`, default 3: BCD digits in the score; full scale is `10^DIGITS - 1` ticks.
- `MIN_WAIT`, default 100: minimum random wait, in ticks.
- `SPAN_LOG2`, default 8: random wait span; wait = `MIN_WAIT + lfsr[SPAN_LOG2-1:0]`. Must satisfy `SPAN_LOG2 ≤ 16`.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clock`, in, 1: single system clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse from the debounced run button.
- `stop`, in, 1: one-cycle pulse from the debounced reaction button.
- `clearBest`, in, 1: level; forces best to all-9s.
- `state`, out, 3: 0 IDLE, 1 WAIT, 2 COUNT, 3 DONE, 4 FOUL.
- `count`, out, 4*DIGITS: current/final score in BCD, digit 0 in LSBs.
- `best`, out, 4*DIGITS: best score in BCD.
- `go`, out, 1: high exactly while `state==COUNT` (drives the LEDs).
- `newBest`, out, 1: one-cycle pulse when best is updated.
- `falseStart`, out, 1: high while in FOUL.
- `overflow`, out, 1: high in DONE when the round ended by saturation.

## Operation
- The LFSR is 16-bit Fibonacci, taps 16,14,13,11. It advances every clock in every state and is never all-zero.
- The prescaler counts 0..DIV-1 and emits `tick` when it reaches DIV-1. It reloads to 0 on every entry to WAIT and to COUNT.
- **IDLE**: on `start`, load `target = MIN_WAIT + lfsr[SPAN_LOG2-1:0]` from the current LFSR value, clear the wait counter, clear `count`, and go to WAIT.
- **WAIT**: the wait counter increments on `tick`.
  - When the counter would reach `target`, go to COUNT.
  - On `start` or `stop`, go to FOUL. The pulse takes priority over a coincident expiry.
- **COUNT**: `count` increments on `tick` as a BCD ripple; each digit wraps 9→0 with carry.
  - `stop` → DONE. `stop` wins over a coincident `tick`, so `count` is not incremented on that edge.
  - A `tick` with `count` at all-9s → DONE with `overflow=1`; `count` holds at all-9s.
  - `start` is ignored.
- **DONE**: on the edge that enters DONE via `stop`, if `count < best` (BCD compare, MSD first), then `best <= count` and `newBest` pulses for the following cycle. Overflow never updates best. `start` begins a new round exactly as from IDLE.
- **FOUL**: `count` holds at 0. `start` begins a new round exactly as from IDLE. `stop` is ignored.
- `clearBest` is valid in any state and sets best to all-9s. If it coincides with a best update, `clearBest` wins and `newBest` stays 0.
- Any input value other than a pulse is treated per cycle; a held `start` re-arms on every cycle it is high in IDLE/DONE/FOUL.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - `state`=IDLE, `count`=0, `best`=all-9s.
  - `go`=0, `newBest`=0, `falseStart`=0, `overflow`=0.
  - `lfsr`=SEED, prescaler=0.
- Reset mid-round aborts immediately and does not preserve best.
- All outputs are registered. The state change is visible one clock after the sampled pulse.
- WAIT→COUNT occurs `target*DIV` clocks after WAIT entry.
- The first `count` increment occurs `DIV` clocks after COUNT entry.
- The score equals the number of complete ticks between `go` rising and `stop` being sampled.
- `newBest` is high for exactly one clock, the cycle after DONE entry.

## Test plan
All scenarios use `CLK_HZ=1000`, `TICK_HZ=100` (DIV=10), `DIGITS=3`, `MIN_WAIT=5`, `SPAN_LOG2=2`.

1. **Reset values**: assert `reset_n=0` mid-COUNT → all outputs at reset values in the same cycle; `best`=12'h999.
2. **Normal round**: `start`, wait for `go`, then `stop` 237 clocks after `go` rises → `state`=DONE, `count`=12'h023, `best`=12'h023, one `newBest` pulse; WAIT lasted 50–80 clocks.
3. **Worse second round**: `start` from DONE, stop at `count`=12'h031 → `best` stays 12'h023, no `newBest`; a further round with score 12'h015 updates best.
4. **False start**: `stop` during WAIT → FOUL, `falseStart`=1, `go` never rises; `start` → WAIT.
5. **Saturation**: no `stop` → `count` reaches 12'h999, then DONE with `overflow=1`; `best` unchanged.
6. **Coincident events**:
   - `stop` on the same cycle as `tick` → count not incremented.
   - `clearBest` with a qualifying `stop` → `best`=12'h999, `newBest`=0.
   - `start` coincident with WAIT expiry → FOUL.

Source files
------------

// File: rtl/reaction_timer_core.sv
// Reaction-time game engine: LFSR-randomised wait, BCD response timer, false-start/overflow detect, best score.
// All outputs registered (state visible one clock after the sampled pulse); pulse inputs only, no backpressure.
module reaction_timer_core #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          TICK_HZ   = 100,
  parameter int          DIGITS    = 3,
  parameter int          MIN_WAIT  = 100,
  parameter int          SPAN_LOG2 = 8,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                clearBest,
  output logic [2:0]          state,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] best,
  output logic                go,
  output logic                newBest,
  output logic                falseStart,
  output logic                overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(MIN_WAIT + (1 << SPAN_LOG2) + 1);
  localparam int CW  = 4 * DIGITS;
  localparam logic [CW-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_COUNT = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;

  state_t          st_q, st_d;
  logic [15:0]     lfsr_q;
  logic            lfsr_fb;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [TW-1:0]   waitcnt_q, waitcnt_d;
  logic [TW-1:0]   target_q, target_d;
  logic [CW-1:0]   count_q, count_d, count_inc;
  logic [CW-1:0]   best_q, best_d;
  logic            newbest_q, newbest_d;
  logic            over_q, over_d;
  logic            go_q, foul_q;
  logic            arm;
  logic            carry;

  // Fibonacci taps 16,14,13,11; a nonzero seed keeps it off the all-zero lockup state.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign tick    = (presc_q == PW'(DIV - 1));

  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    st_d      = st_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    waitcnt_d = waitcnt_q;
    target_d  = target_q;
    count_d   = count_q;
    best_d    = best_q;
    newbest_d = 1'b0;
    over_d    = over_q;
    arm       = 1'b0;

    case (st_q)
      S_IDLE: arm = start;
      S_WAIT: begin
        // A button pulse beats a coincident expiry.
        if (start || stop) begin
          st_d = S_FOUL;
        end else if (tick) begin
          if (waitcnt_q + TW'(1) >= target_q) begin
            st_d    = S_COUNT;
            presc_d = '0;
          end else begin
            waitcnt_d = waitcnt_q + TW'(1);
          end
        end
      end
      S_COUNT: begin
        if (stop) begin
          st_d = S_DONE;
          // Packed BCD with MSD in the MSBs orders the same as the decimal value.
          if (count_q < best_q) begin
            best_d    = count_q;
            newbest_d = 1'b1;
          end
        end else if (tick) begin
          if (count_q == ALL9) begin
            st_d   = S_DONE;
            over_d = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
      end
      S_DONE: arm = start;
      S_FOUL: arm = start;
      default: st_d = S_IDLE;
    endcase

    if (arm) begin
      st_d      = S_WAIT;
      target_d  = TW'(MIN_WAIT) + TW'(lfsr_q[SPAN_LOG2-1:0]);
      waitcnt_d = '0;
      count_d   = '0;
      over_d    = 1'b0;
      presc_d   = '0;
    end

    if (clearBest) begin
      best_d    = ALL9;
      newbest_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= S_IDLE;
      lfsr_q    <= SEED;
      presc_q   <= '0;
      waitcnt_q <= '0;
      target_q  <= '0;
      count_q   <= '0;
      best_q    <= ALL9;
      newbest_q <= 1'b0;
      over_q    <= 1'b0;
      go_q      <= 1'b0;
      foul_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
      presc_q   <= presc_d;
      waitcnt_q <= waitcnt_d;
      target_q  <= target_d;
      count_q   <= count_d;
      best_q    <= best_d;
      newbest_q <= newbest_d;
      over_q    <= over_d;
      go_q      <= (st_d == S_COUNT);
      foul_q    <= (st_d == S_FOUL);
    end
  end

  assign state      = st_q;
  assign count      = count_q;
  assign best       = best_q;
  assign go         = go_q;
  assign newBest    = newbest_q;
  assign falseStart = foul_q;
  assign overflow   = over_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: elapsed-time model compared every cycle, plus directed rounds with literal expectations.
module tb_reaction_timer_core;
  localparam int DIV      = 10;
  localparam int MIN_WAIT = 5;
  localparam int FULL     = 999;

  logic        clock, reset_n, start, stop, clearBest;
  logic [2:0]  state;
  logic [11:0] count, best;
  logic        go, newBest, falseStart, overflow;

  int vectors = 0;
  int errors  = 0;

  reaction_timer_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(3), .MIN_WAIT(MIN_WAIT), .SPAN_LOG2(2), .SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clearBest(clearBest),
    .state(state), .count(count), .best(best), .go(go), .newBest(newBest),
    .falseStart(falseStart), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: phase entry edge plus elapsed edges gives ticks directly (one tick per DIV edges).
  int          m_st, m_t0, m_tgt, m_count, m_best, m_cyc;
  logic        m_nb, m_ov;
  logic [15:0] m_lfsr;

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_t0 = 0; m_tgt = 0; m_count = 0; m_best = FULL; m_cyc = 0;
    m_nb = 1'b0; m_ov = 1'b0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic s, input logic p, input logic c);
    int  e;
    logic arm;
    m_cyc++;
    e   = m_cyc - m_t0;
    m_nb = 1'b0;
    arm = 1'b0;
    case (m_st)
      1: if (s || p) m_st = 4;
         else if (e == m_tgt * DIV) begin m_st = 2; m_t0 = m_cyc; end
      2: if (p) begin
           m_st = 3; m_count = (e - 1) / DIV;
           if (m_count < m_best) begin m_best = m_count; m_nb = 1'b1; end
         end else if (e == (FULL + 1) * DIV) begin
           m_st = 3; m_ov = 1'b1; m_count = FULL;
         end else m_count = e / DIV;
      default: arm = s;
    endcase
    if (arm) begin
      m_st = 1; m_tgt = MIN_WAIT + int'(m_lfsr[1:0]); m_t0 = m_cyc; m_count = 0; m_ov = 1'b0;
    end
    if (c) begin m_best = FULL; m_nb = 1'b0; end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step(start, stop, clearBest);
    end
  end

  initial begin
    logic [30:0] exp_v, act_v;
    forever begin
      @(negedge clock);
      exp_v = {3'(m_st), to_bcd(m_count), to_bcd(m_best), m_st == 2, m_nb, m_st == 4, m_ov};
      act_v = {state, count, best, go, newBest, falseStart, overflow};
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t dut st=%0d cnt=%h best=%h go=%b nb=%b fs=%b ov=%b, model st=%0d cnt=%h best=%h go=%b nb=%b fs=%b ov=%b",
                 $time, state, count, best, go, newBest, falseStart, overflow,
                 exp_v[30:28], exp_v[27:16], exp_v[15:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_go(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (go !== 1'b1 && k < 200);
    check("go_seen", 32'(go), 32'd1);
  endtask

  // Start a round, then have stop sampled on the k-th edge after go rises.
  task automatic play(input int k, input logic clr, output int wlen);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_go(wlen);
    repeat (k - 1) @(negedge clock);
    stop = 1'b1; clearBest = clr;
    @(negedge clock);
    stop = 1'b0; clearBest = 1'b0;
  endtask

  initial begin
    int  w, n;
    logic saw_go;
    start = 1'b0; stop = 1'b0; clearBest = 1'b0; reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", 32'(state), 32'd0);
    check("rst_best", 32'(best), 32'h999);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Normal round: 237 edges after go -> 23 complete ticks.
    play(237, 1'b0, w);
    check("wait_len_range", 32'((w >= 50) && (w <= 80) && (w % 10 == 0)), 32'd1);
    check("r1_state", 32'(state), 32'd3);
    check("r1_count", 32'(count), 32'h023);
    check("r1_best", 32'(best), 32'h023);
    check("r1_newbest", 32'(newBest), 32'd1);
    @(negedge clock);
    check("r1_newbest_drop", 32'(newBest), 32'd0);

    // Worse round, then better round with stop coincident with the 16th tick.
    play(315, 1'b0, w);
    check("r2_count", 32'(count), 32'h031);
    check("r2_best", 32'(best), 32'h023);
    check("r2_newbest", 32'(newBest), 32'd0);
    play(160, 1'b0, w);
    check("r3_count_stop_on_tick", 32'(count), 32'h015);
    check("r3_best", 32'(best), 32'h015);
    check("r3_newbest", 32'(newBest), 32'd1);

    // False start.
    start = 1'b1; @(negedge clock); start = 1'b0;
    repeat (20) @(negedge clock);
    stop = 1'b1; @(negedge clock); stop = 1'b0;
    check("foul_state", 32'(state), 32'd4);
    check("foul_flag", 32'(falseStart), 32'd1);
    check("foul_count", 32'(count), 32'h000);
    saw_go = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (go === 1'b1) saw_go = 1'b1;
    end
    check("foul_no_go", 32'(saw_go), 32'd0);
    start = 1'b1; @(negedge clock); start = 1'b0;
    check("foul_restart", 32'(state), 32'd1);

    // Saturation with an ignored start mid-count.
    wait_go(w);
    n = 0;
    repeat (49) begin @(negedge clock); n++; end
    start = 1'b1; @(negedge clock); n++; start = 1'b0;
    check("count_ignores_start", 32'(state), 32'd2);
    while (state !== 3'd3 && n < 10100) begin @(negedge clock); n++; end
    check("sat_cycles", 32'(n), 32'd10000);
    check("sat_count", 32'(count), 32'h999);
    check("sat_overflow", 32'(overflow), 32'd1);
    check("sat_best", 32'(best), 32'h015);
    check("sat_newbest", 32'(newBest), 32'd0);

    // clearBest coincident with a qualifying stop.
    play(21, 1'b1, w);
    check("clr_count", 32'(count), 32'h002);
    check("clr_best", 32'(best), 32'h999);
    check("clr_newbest", 32'(newBest), 32'd0);

    // start sampled on the same edge as WAIT expiry.
    start = 1'b1; @(negedge clock); start = 1'b0;
    repeat (m_tgt * DIV - 1) @(negedge clock);
    start = 1'b1; @(negedge clock); start = 1'b0;
    check("expiry_start_foul", 32'(state), 32'd4);
    check("expiry_start_go", 32'(go), 32'd0);

    // Reset mid-COUNT takes effect without a clock edge.
    start = 1'b1; @(negedge clock); start = 1'b0;
    wait_go(w);
    repeat (30) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_count", 32'(count), 32'h000);
    check("arst_best", 32'(best), 32'h999);
    check("arst_go", 32'(go), 32'd0);
    check("arst_newbest", 32'(newBest), 32'd0);
    check("arst_falsestart", 32'(falseStart), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_idle", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
